// File: rtl/pipeline_seq_pkg.sv
// Shared types and default sizing for the decode-stage stall/flush sequencer.
package pipeline_seq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } seq_state_e;

   localparam int PASS_W_DEF = 2;
   localparam int REG_W_DEF  = 3;

endpackage

// File: rtl/pipeline_sequencer_load_use_detect.sv
// Combinational load-use hazard compare between the decode sources and the execute load.
module load_use_detect
   import pipeline_seq_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic [REG_W-1:0] ra1_d,
   input  logic [REG_W-1:0] ra2_d,
   input  logic [REG_W-1:0] wa3_e,
   input  logic             reg_write_e,
   input  logic             mem_to_reg_e,
   output logic             load_use
);

   assign load_use = reg_write_e & mem_to_reg_e & ((wa3_e == ra1_d) | (wa3_e == ra2_d));

endmodule

// File: rtl/pipeline_sequencer.sv
// Decode-stage stall/flush sequencer with multi-pass re-issue.
// Optional stall-cycle counter enabled by defining PIPELINE_SEQ_PERF_EN.
module pipeline_sequencer
   import pipeline_seq_pkg::*;
#(
   parameter int PASS_W = PASS_W_DEF,
   parameter int REG_W  = REG_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              StuckD,
   input  logic [PASS_W-1:0] PassCountD,
   input  logic [REG_W-1:0]  RA1D,
   input  logic [REG_W-1:0]  RA2D,
   input  logic [REG_W-1:0]  WA3E,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              BranchTakenE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic [PASS_W-1:0] PassIdx,
   output logic              LastPass,
`ifdef PIPELINE_SEQ_PERF_EN
   output logic [31:0]       StallCycles,
`endif
   output logic              Busy
);

   seq_state_e        state_reg, state_next;
   logic [PASS_W-1:0] cnt_reg, cnt_next;
   logic [PASS_W-1:0] tot_reg, tot_next;
   logic              load_use;
   logic              stall, flush_d, flush_e, last_pass, busy;
   logic [PASS_W-1:0] pass_idx;

   load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
      .ra1_d        (RA1D),
      .ra2_d        (RA2D),
      .wa3_e        (WA3E),
      .reg_write_e  (RegWriteE),
      .mem_to_reg_e (MemtoRegE),
      .load_use     (load_use)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         tot_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         tot_reg   <= tot_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      tot_next   = tot_reg;
      stall      = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      pass_idx   = '0;
      last_pass  = 1'b1;
      busy       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (BranchTakenE) begin
               flush_d = 1'b1;
               flush_e = 1'b1;
            end else if (load_use) begin
               // Bubble first; a pending multi-pass start waits one cycle.
               stall   = 1'b1;
               flush_e = 1'b1;
            end else if (StuckD && (PassCountD != '0)) begin
               stall      = 1'b1;
               last_pass  = 1'b0;
               tot_next   = PassCountD;
               cnt_next   = PASS_W'(1);
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            pass_idx = cnt_reg;
            busy     = 1'b1;
            if (BranchTakenE) begin
               flush_d    = 1'b1;
               flush_e    = 1'b1;
               last_pass  = 1'b0;
               cnt_next   = '0;
               state_next = IDLE;
            end else if (cnt_reg != tot_reg) begin
               stall     = 1'b1;
               last_pass = 1'b0;
               cnt_next  = cnt_reg + PASS_W'(1);
            end else begin
               cnt_next   = '0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // Outputs read as idle for the whole reset cycle, whatever the state.
      if (reset) begin
         stall     = 1'b0;
         flush_d   = 1'b0;
         flush_e   = 1'b0;
         pass_idx  = '0;
         last_pass = 1'b1;
         busy      = 1'b0;
      end
   end

   assign StallF   = stall;
   assign StallD   = stall;
   assign FlushD   = flush_d;
   assign FlushE   = flush_e;
   assign PassIdx  = pass_idx;
   assign LastPass = last_pass;
   assign Busy     = busy;

`ifdef PIPELINE_SEQ_PERF_EN
   logic [31:0] stall_cycles_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_reg <= '0;
      end else if (stall && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
         stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
   end

   assign StallCycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer (checks StallCycles when PIPELINE_SEQ_PERF_EN is defined).
module tb_pipeline_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       StuckD;
   logic [1:0] PassCountD;
   logic [2:0] RA1D, RA2D, WA3E;
   logic       RegWriteE, MemtoRegE, BranchTakenE;
   logic       StallF, StallD, FlushD, FlushE, LastPass, Busy;
   logic [1:0] PassIdx;
`ifdef PIPELINE_SEQ_PERF_EN
   logic [31:0] StallCycles;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   pipeline_sequencer #(.PASS_W(2), .REG_W(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .StuckD       (StuckD),
      .PassCountD   (PassCountD),
      .RA1D         (RA1D),
      .RA2D         (RA2D),
      .WA3E         (WA3E),
      .RegWriteE    (RegWriteE),
      .MemtoRegE    (MemtoRegE),
      .BranchTakenE (BranchTakenE),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .PassIdx      (PassIdx),
      .LastPass     (LastPass),
`ifdef PIPELINE_SEQ_PERF_EN
      .StallCycles  (StallCycles),
`endif
      .Busy         (Busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Compare the full control vector against hand-computed values; one line per transaction.
   task automatic expect_ctrl(input string tag, input logic stall, input logic fd, input logic fe,
                              input logic [1:0] idx, input logic last, input logic busy);
      #1;
      $display("[%0t] %s: StallF=%0b StallD=%0b FlushD=%0b FlushE=%0b PassIdx=%0d LastPass=%0b Busy=%0b",
               $time, tag, StallF, StallD, FlushD, FlushE, PassIdx, LastPass, Busy);
      check({tag, ".StallF"},   {31'd0, StallF},   {31'd0, stall});
      check({tag, ".StallD"},   {31'd0, StallD},   {31'd0, stall});
      check({tag, ".FlushD"},   {31'd0, FlushD},   {31'd0, fd});
      check({tag, ".FlushE"},   {31'd0, FlushE},   {31'd0, fe});
      check({tag, ".PassIdx"},  {30'd0, PassIdx},  {30'd0, idx});
      check({tag, ".LastPass"}, {31'd0, LastPass}, {31'd0, last});
      check({tag, ".Busy"},     {31'd0, Busy},     {31'd0, busy});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      StuckD = 0; PassCountD = 0; RA1D = 0; RA2D = 0; WA3E = 0;
      RegWriteE = 0; MemtoRegE = 0; BranchTakenE = 0;
   endtask

   task automatic set_load_use();
      WA3E = 3'd3; RegWriteE = 1; MemtoRegE = 1; RA1D = 3'd1; RA2D = 3'd3;
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      StuckD = 1; PassCountD = 2'd3;
      tick(); tick();
      // Reset forces idle-looking outputs even with a multi-pass request present
      expect_ctrl("reset", 0, 0, 0, 2'd0, 1, 0);

      reset = 0;
      clear_inputs();
      expect_ctrl("idle", 0, 0, 0, 2'd0, 1, 0);
      tick();

      // Load-use: one bubble, released once E holds the bubble
      set_load_use();
      expect_ctrl("loaduse", 1, 0, 1, 2'd0, 1, 0);
      tick();
      clear_inputs();
      expect_ctrl("loaduse_after", 0, 0, 0, 2'd0, 1, 0);
      tick();

      // Multi-pass, PassCountD=3; later PassCountD changes are ignored
      StuckD = 1; PassCountD = 2'd3;
      expect_ctrl("mp3_p0", 1, 0, 0, 2'd0, 0, 0);
      tick();
      PassCountD = 2'd0;
      expect_ctrl("mp3_p1", 1, 0, 0, 2'd1, 0, 1);
      tick();
      expect_ctrl("mp3_p2", 1, 0, 0, 2'd2, 0, 1);
      tick();
      expect_ctrl("mp3_p3", 0, 0, 0, 2'd3, 1, 1);
      tick();
      StuckD = 0;
      expect_ctrl("mp3_done", 0, 0, 0, 2'd0, 1, 0);
`ifdef PIPELINE_SEQ_PERF_EN
      check("stall_cycles", StallCycles, 32'd4);
`endif
      tick();

      // Branch beats load-use and multi-pass start
      set_load_use();
      StuckD = 1; PassCountD = 2'd2; BranchTakenE = 1;
      expect_ctrl("branch_prio", 0, 1, 1, 2'd0, 1, 0);
      tick();
      clear_inputs();
      expect_ctrl("branch_prio_after", 0, 0, 0, 2'd0, 1, 0);
      tick();

      // Reset in the middle of a 3-pass sequence
      StuckD = 1; PassCountD = 2'd2;
      expect_ctrl("rst_mid_p0", 1, 0, 0, 2'd0, 0, 0);
      tick();
      reset = 1;
      expect_ctrl("rst_mid_during", 0, 0, 0, 2'd0, 1, 0);
      tick();
      reset = 0;
      StuckD = 0;
      expect_ctrl("rst_mid_after", 0, 0, 0, 2'd0, 1, 0);
      tick();

      // Single pass: no stall
      StuckD = 1; PassCountD = 2'd0;
      expect_ctrl("single", 0, 0, 0, 2'd0, 1, 0);
      tick();
      StuckD = 0;
      expect_ctrl("single_after", 0, 0, 0, 2'd0, 1, 0);
      tick();

      // Branch abort while issuing
      StuckD = 1; PassCountD = 2'd3;
      expect_ctrl("abort_p0", 1, 0, 0, 2'd0, 0, 0);
      tick();
      BranchTakenE = 1;
      expect_ctrl("abort_p1", 0, 1, 1, 2'd1, 0, 1);
      tick();
      clear_inputs();
      expect_ctrl("abort_after", 0, 0, 0, 2'd0, 1, 0);
      tick();

      // Multi-pass behind a load-use starts one cycle later
      set_load_use();
      StuckD = 1; PassCountD = 2'd1;
      expect_ctrl("lu_mp_bubble", 1, 0, 1, 2'd0, 1, 0);
      tick();
      RegWriteE = 0; MemtoRegE = 0;
      expect_ctrl("lu_mp_p0", 1, 0, 0, 2'd0, 0, 0);
      tick();
      expect_ctrl("lu_mp_p1", 0, 0, 0, 2'd1, 1, 1);
      tick();
      clear_inputs();
      expect_ctrl("lu_mp_done", 0, 0, 0, 2'd0, 1, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
